miner_result_serializer: RTL and testbench
==========================================

Name: miner_result_serializer

Overview:
- Downstream of the miner top level.
- Captures the 288-bit result word (256-bit hash, then 32-bit nonce) when the miner raises send_data.
- Streams the word out MSB-first as 36 bytes over a valid/ready byte interface feeding the host-link transmitter.
- Flags result events lost while a transmission is in progress.

Parameters:
- NUM_BYTES, 36, number of bytes per result word.
- DATA_WIDTH, 288, result word width; must equal 8*NUM_BYTES.

Ports:
- clk  input  1  system clock
- n_rst  input  1  asynchronous active-low reset
- send_data  input  1  result-available level from miner; a new result is signalled by its rising edge
- tx_data  input  DATA_WIDTH  result word {hash[255:0], nonce[31:0]}; valid while send_data high
- byte_ready  input  1  downstream accepts byte_out this cycle
- byte_out  output  8  current byte
- byte_valid  output  1  byte_out valid
- busy  output  1  high while a word is held or being sent
- done  output  1  one-cycle pulse after the last byte is accepted
- overrun  output  1  sticky; set when a rising edge of send_data is ignored

Behaviour:
- Reset (n_rst=0, async): state=IDLE, shift register=0, byte count=0, send_data edge register=0, byte_out=0, byte_valid=0, busy=0, done=0, overrun=0.
- Edge detect: send_q is a registered copy of send_data. start = send_data & ~send_q. A level held for many cycles produces exactly one start.
- States: IDLE, SEND, DONE.
- IDLE:
  - byte_valid=0, busy=0.
  - On start: load tx_data into the shift register, clear count, clear overrun, go to SEND on the next edge.
  - Latency: byte_valid is high the cycle after the rising edge of send_data.
- SEND:
  - byte_valid=1, busy=1, byte_out = shift register[DATA_WIDTH-1 -: 8].
  - A transfer occurs when byte_valid & byte_ready at a clock edge.
  - On a transfer: shift left by 8 and increment count.
  - If count==NUM_BYTES-1 at the transfer, go to DONE.
  - With no transfer, byte_out and byte_valid hold stable. byte_valid never drops before acceptance.
- DONE:
  - byte_valid=0, busy=1, done=1 for exactly one cycle, then IDLE.
- Byte order:
  - byte 0 = tx_data[287:280] (hash MSB).
  - byte 31 = tx_data[39:32] (hash LSB).
  - bytes 32..35 = nonce MSB to LSB.
- Overrun:
  - A start in SEND or DONE is ignored and sets overrun. The captured word is unaffected.
  - overrun clears only on the next accepted start or on reset.
  - A start in the same cycle DONE→IDLE occurs counts as overrun; the first start accepted is one seen in IDLE.
- send_data falling, or tx_data changing during SEND, has no effect on the captured word.
- byte_ready while byte_valid=0 is ignored.
- Count width: ceil(log2(NUM_BYTES)); no wrap beyond NUM_BYTES-1.
- Reset asserted mid-transfer aborts immediately. byte_valid drops asynchronously and no done pulse is produced.
- Throughput: with byte_ready held high, 36 bytes take 36 consecutive cycles. Minimum start-to-start spacing is 38 cycles.

Test Plan:
- Reset check: drive n_rst=0 mid-simulation with random inputs -> byte_valid=0, busy=0, done=0, overrun=0, byte_out=8'h00 asynchronously.
- Basic send:
  - Stimulus: tx_data = {256'h00112233...EEFF repeated pattern, 32'hDEADBEEF}, send_data high for 1 cycle, byte_ready=1.
  - Response: 36 consecutive bytes, first 8'h00, last four 8'hDE, 8'hAD, 8'hBE, 8'hEF; done pulses 1 cycle after the last byte; busy low afterwards.
- Held level: send_data high for 100 cycles with a constant tx_data -> exactly one 36-byte frame and overrun=0.
- Backpressure:
  - Stimulus: byte_ready toggles 1,0,0,1 repeating.
  - Response: byte_out/byte_valid stable during every ready=0 cycle; the same 36-byte sequence as the basic send; done only after the 36th acceptance.
- Overrun:
  - Stimulus: second send_data rising edge at byte 10 with tx_data=288'h1.
  - Response: frame still carries the first word; overrun=1 until the next start in IDLE, which clears it and sends 35×8'h00 then 8'h01.
- Reset mid-frame: assert n_rst at byte 20 -> no done pulse; after release and a new start, a full 36-byte frame from byte 0.

Source files
------------

// File: rtl/miner_result_serializer.sv
// ----------------------------------------------------------------------------
// miner_result_serializer
//
// Captures a miner result word {hash[255:0], nonce[31:0]} on the rising edge
// of send_data and streams it out MSB-first as NUM_BYTES bytes over a
// valid/ready byte interface toward the host-link transmitter.
//
// Handshake: byte_out/byte_valid form a strict valid/ready source. A byte
// transfers on a clock edge where byte_valid & byte_ready are both high. Once
// byte_valid is raised it stays high, with byte_out stable, until that byte
// is accepted. byte_ready is ignored while byte_valid is low.
//
// Ports:
//   clk         in   system clock
//   n_rst       in   asynchronous active-low reset
//   send_data   in   result-available level; its rising edge starts a frame
//   tx_data     in   DATA_WIDTH result word, sampled only on an accepted start
//   byte_ready  in   downstream accepts byte_out this cycle
//   byte_out    out  current byte (top byte of the shift register)
//   byte_valid  out  byte_out is valid
//   busy        out  high while a word is held or being sent
//   done        out  one-cycle pulse after the last byte is accepted
//   overrun     out  sticky; a start arrived while not IDLE and was dropped
//   state_dbg   out  current FSM state (IDLE=0, SEND=1, DONE=2)
//
// DATA_WIDTH must equal 8*NUM_BYTES.
// ----------------------------------------------------------------------------
module miner_result_serializer #(
  parameter int NUM_BYTES  = 36,
  parameter int DATA_WIDTH = 288
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  send_data,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  byte_ready,
  output logic [7:0]            byte_out,
  output logic                  byte_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  overrun,
  output logic [1:0]            state_dbg
);

  localparam int CW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [CW-1:0]         count_q;
  logic                  send_q;
  logic                  byte_valid_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  overrun_q;

  // A level held high for many cycles yields exactly one start.
  logic start;
  assign start = send_data & ~send_q;

  logic xfer;
  assign xfer = byte_valid_q & byte_ready;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      count_q      <= '0;
      send_q       <= 1'b0;
      byte_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      send_q <= send_data;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            shift_q      <= tx_data;
            count_q      <= '0;
            overrun_q    <= 1'b0;
            byte_valid_q <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= SEND;
          end
        end
        SEND: begin
          // The captured word is never disturbed by a late start.
          if (start) overrun_q <= 1'b1;
          if (xfer) begin
            shift_q <= {shift_q[DATA_WIDTH-9:0], 8'h00};
            if (count_q == LAST_IDX) begin
              byte_valid_q <= 1'b0;
              done_q       <= 1'b1;
              state_q      <= DONE;
            end else begin
              count_q <= count_q + CW'(1);
            end
          end
        end
        DONE: begin
          // A start on the DONE->IDLE edge is still dropped.
          if (start) overrun_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          byte_valid_q <= 1'b0;
          busy_q       <= 1'b0;
          state_q      <= IDLE;
        end
      endcase
    end
  end

  // The top byte of the shift register is the byte on offer; it only moves
  // on a transfer, which keeps byte_out stable under backpressure.
  assign byte_out   = shift_q[DATA_WIDTH-1 -: 8];
  assign byte_valid = byte_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign overrun    = overrun_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_miner_result_serializer.sv
module tb_miner_result_serializer;

  localparam int NB = 36;
  localparam int W  = 288;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         n_rst;
  logic         send_data;
  logic [W-1:0] tx_data;
  logic         byte_ready;
  logic [7:0]   byte_out;
  logic         byte_valid;
  logic         busy;
  logic         done;
  logic         overrun;
  logic [1:0]   state_dbg;

  always #5 clk = ~clk;

  miner_result_serializer #(.NUM_BYTES(NB), .DATA_WIDTH(W)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .send_data  (send_data),
    .tx_data    (tx_data),
    .byte_ready (byte_ready),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .busy       (busy),
    .done       (done),
    .overrun    (overrun),
    .state_dbg  (state_dbg)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int         frame_cnt   = 0;
  int         frames_done = 0;
  int         cyc         = 0;
  int         first_cyc   = 0;
  int         last_cyc    = 0;
  logic       done_exp    = 1'b0;
  logic       prev_stall  = 1'b0;
  logic [7:0] prev_byte   = 8'h00;

  // Inputs change #1 after posedge, so the values seen here at negedge are
  // the ones the DUT will sample on the next posedge.
  always @(negedge clk) begin
    logic [7:0] e;
    cyc++;
    if (!n_rst) begin
      frame_cnt  = 0;
      done_exp   = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (done_exp || done) check_eq("done_pulse", done, done_exp);
      if (done) frames_done++;
      done_exp = 1'b0;
      if (prev_stall) begin
        check_eq("hold_valid", byte_valid, 1);
        check_eq("hold_byte", byte_out, prev_byte);
      end
      if (byte_valid && byte_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_byte", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check_eq("byte", byte_out, e);
        end
        frame_cnt++;
        if (frame_cnt == 1) first_cyc = cyc;
        if (frame_cnt == NB) begin
          last_cyc  = cyc;
          done_exp  = 1'b1;
          frame_cnt = 0;
        end
      end
      prev_stall = byte_valid && !byte_ready;
      prev_byte  = byte_out;
    end
  end

  // ---------------- ready driver ----------------
  int         bp_mode = 0;   // 0: always ready, 1: 1,0,0,1 pattern, 2: random
  int         bp_ph   = 0;
  logic [3:0] bp_pat  = 4'b1001;

  always @(posedge clk) begin
    #1;
    if (bp_mode == 1) begin
      byte_ready = bp_pat[bp_ph];
      bp_ph      = (bp_ph + 1) % 4;
    end else if (bp_mode == 2) begin
      byte_ready = 1'($urandom_range(0, 1));
    end else begin
      byte_ready = 1'b1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_word(input logic [W-1:0] data, input bit accept, input int hold);
    @(posedge clk); #1;
    tx_data   = data;
    send_data = 1'b1;
    if (accept)
      for (int i = 0; i < NB; i++) exp_q.push_back(data[W-1-8*i -: 8]);
    @(posedge clk); #1;
    if (accept) begin
      check_eq("start_valid", byte_valid, 1);
      check_eq("start_busy", busy, 1);
      check_eq("start_ovr_clr", overrun, 0);
    end else begin
      check_eq("ovr_set", overrun, 1);
    end
    for (int i = 1; i < hold; i++) @(posedge clk);
    #1;
    send_data = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      if (!busy && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_eq({tag, "_timeout"}, 1, 0);
  endtask

  task automatic wait_bytes(input int n);
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (frame_cnt >= n) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_eq("wait_bytes_timeout", 1, 0);
  endtask

  // ---------------- main sequence ----------------
  logic [W-1:0] basic_w;
  int           fd0;

  initial begin
    basic_w    = {{2{128'h00112233445566778899AABBCCDDEEFF}}, 32'hDEADBEEF};
    n_rst      = 1'b1;
    send_data  = 1'b0;
    tx_data    = '0;
    byte_ready = 1'b0;
    #2 n_rst = 1'b0;
    #2;
    check_eq("rst_valid", byte_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_ovr", overrun, 0);
    check_eq("rst_byte", byte_out, 8'h00);
    check_eq("rst_state", state_dbg, 0);
    repeat (3) @(posedge clk);
    #1 n_rst = 1'b1;
    repeat (2) @(posedge clk);

    // Basic send, ready always high.
    fd0 = frames_done;
    start_word(basic_w, 1'b1, 1);
    wait_idle("basic");
    check_eq("basic_burst", 32'(last_cyc - first_cyc), NB - 1);
    check_eq("basic_frames", 32'(frames_done - fd0), 1);
    check_eq("basic_busy_low", busy, 0);
    check_eq("basic_ovr", overrun, 0);

    // Held level: one frame only.
    fd0 = frames_done;
    start_word({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 1'b1, 100);
    wait_idle("held");
    repeat (5) @(posedge clk);
    check_eq("held_frames", 32'(frames_done - fd0), 1);
    check_eq("held_ovr", overrun, 0);

    // Backpressure 1,0,0,1.
    fd0     = frames_done;
    bp_ph   = 0;
    bp_mode = 1;
    start_word(basic_w, 1'b1, 1);
    wait_idle("bp");
    bp_mode = 0;
    check_eq("bp_frames", 32'(frames_done - fd0), 1);

    // Random backpressure with random data.
    bp_mode = 2;
    start_word({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 1'b1, 3);
    wait_idle("rand_bp");
    bp_mode = 0;

    // Overrun: second start mid-frame is dropped.
    start_word(basic_w, 1'b1, 1);
    wait_bytes(10);
    start_word(288'h1, 1'b0, 1);
    wait_idle("ovr_frame");
    check_eq("ovr_sticky", overrun, 1);
    repeat (4) @(posedge clk);
    #1 check_eq("ovr_sticky2", overrun, 1);
    start_word(288'h1, 1'b1, 1);
    wait_idle("ovr_next");
    check_eq("ovr_after", overrun, 0);

    // Reset mid-frame.
    start_word(basic_w, 1'b1, 1);
    wait_bytes(20);
    fd0 = frames_done;
    @(posedge clk); #1;
    n_rst     = 1'b0;
    bp_mode   = 2;
    send_data = 1'($urandom_range(0, 1));
    tx_data   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    #1;
    check_eq("mid_rst_valid", byte_valid, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_done", done, 0);
    check_eq("mid_rst_ovr", overrun, 0);
    check_eq("mid_rst_byte", byte_out, 8'h00);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    send_data = 1'b0;
    bp_mode   = 0;
    n_rst     = 1'b1;
    repeat (3) @(posedge clk);
    check_eq("mid_rst_no_done", 32'(frames_done - fd0), 0);
    start_word(basic_w, 1'b1, 1);
    wait_idle("post_rst");
    check_eq("post_rst_frames", 32'(frames_done - fd0), 1);
    check_eq("post_rst_q", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
